// File: rtl/fpu_multiplier_param.sv
// Parametrised-format IEEE-754 multiplier with strobe/ack operand handshakes,
// selectable rounding mode, flush-to-zero inputs and {NV,OF,UF,NX} flags.
module fpu_multiplier_param #(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 23,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] input_a,
  input  logic         input_a_stb,
  output logic         input_a_ack,
  input  logic [1:0]   input_rm,
  input  logic [W-1:0] input_b,
  input  logic         input_b_stb,
  output logic         input_b_ack,
  output logic [W-1:0] output_z,
  output logic         output_z_stb,
  input  logic         output_z_ack,
  output logic [3:0]   output_flags
);

  localparam int PW   = 2 * MAN_W + 2;
  localparam int EW   = EXP_W + 2;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int EMAX = (1 << EXP_W) - 1;
  localparam logic signed [EW-1:0] EMAX_S = EW'(EMAX);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {GET_A, GET_B, UNPACK, SPECIAL, MULT, NORM, ROUND, PUT_Z} state_t;

  state_t                 state_q, state_d;
  logic [W-1:0]           a_q, a_d, b_q, b_d, z_q, z_d;
  logic [1:0]             rm_q, rm_d;
  logic                   a_ack_q, a_ack_d, b_ack_q, b_ack_d, z_stb_q, z_stb_d;
  logic [3:0]             flags_q, flags_d;
  logic                   s_q, s_d;
  logic signed [EW-1:0]   exp_q, exp_d;
  logic [MAN_W:0]         ma_q, ma_d, mb_q, mb_d;
  logic [PW-1:0]          prod_q, prod_d;
  logic [MAN_W-1:0]       frac_q, frac_d;
  logic                   g_q, g_d, st_q, st_d;

  logic [EXP_W-1:0]       ea, eb;
  logic                   a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
  logic                   rnd_inc;
  logic [MAN_W:0]         rnd_sum;
  logic signed [EW-1:0]   exp_rnd;
  logic [W-1:0]           inf_z, max_z;

  assign ea     = a_q[W-2 -: EXP_W];
  assign eb     = b_q[W-2 -: EXP_W];
  assign a_nan  = (&ea) && (|a_q[MAN_W-1:0]);
  assign b_nan  = (&eb) && (|b_q[MAN_W-1:0]);
  assign a_snan = a_nan && !a_q[MAN_W-1];
  assign b_snan = b_nan && !b_q[MAN_W-1];
  assign a_inf  = (&ea) && !(|a_q[MAN_W-1:0]);
  assign b_inf  = (&eb) && !(|b_q[MAN_W-1:0]);
  // Subnormals are flushed: a zero exponent field is treated as zero.
  assign a_zero = ~|ea;
  assign b_zero = ~|eb;
  assign inf_z  = {s_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  assign max_z  = {s_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    rm_d    = rm_q;
    z_d     = z_q;
    flags_d = flags_q;
    s_d     = s_q;
    exp_d   = exp_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    prod_d  = prod_q;
    frac_d  = frac_q;
    g_d     = g_q;
    st_d    = st_q;
    rnd_inc = 1'b0;
    rnd_sum = '0;
    exp_rnd = '0;
    case (state_q)
      GET_A: if (input_a_stb && a_ack_q) begin
        a_d     = input_a;
        rm_d    = input_rm;
        flags_d = '0;
        state_d = GET_B;
      end
      GET_B: if (input_b_stb && b_ack_q) begin
        b_d     = input_b;
        state_d = UNPACK;
      end
      UNPACK: begin
        s_d     = a_q[W-1] ^ b_q[W-1];
        exp_d   = EW'(ea) + EW'(eb) - EW'(BIAS);
        ma_d    = {1'b1, a_q[MAN_W-1:0]};
        mb_d    = {1'b1, b_q[MAN_W-1:0]};
        state_d = SPECIAL;
      end
      SPECIAL: begin
        state_d = PUT_Z;
        if (a_nan || b_nan) begin
          z_d     = QNAN;
          flags_d = {a_snan || b_snan, 3'b000};
        end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
          z_d     = QNAN;
          flags_d = 4'b1000;
        end else if (a_inf || b_inf) begin
          z_d     = inf_z;
        end else if (a_zero || b_zero) begin
          z_d     = {s_q, {(W-1){1'b0}}};
        end else begin
          state_d = MULT;
        end
      end
      MULT: begin
        prod_d  = PW'(ma_q) * PW'(mb_q);
        state_d = NORM;
      end
      NORM: begin
        // Product of two 1.f values lies in [1,4): at most one right shift.
        if (prod_q[PW-1]) begin
          frac_d = prod_q[PW-2 -: MAN_W];
          g_d    = prod_q[MAN_W];
          st_d   = |prod_q[MAN_W-1:0];
          exp_d  = exp_q + EW'(1);
        end else begin
          frac_d = prod_q[PW-3 -: MAN_W];
          g_d    = prod_q[MAN_W-1];
          st_d   = |prod_q[MAN_W-2:0];
        end
        state_d = ROUND;
      end
      ROUND: begin
        unique case (rm_q)
          2'b00: rnd_inc = g_q && (st_q || frac_q[0]);
          2'b01: rnd_inc = 1'b0;
          2'b10: rnd_inc = (g_q || st_q) && !s_q;
          2'b11: rnd_inc = (g_q || st_q) && s_q;
        endcase
        // Hidden bit is always 1, so a carry out of the fraction is the mantissa carry.
        rnd_sum = {1'b0, frac_q} + (MAN_W+1)'(rnd_inc);
        exp_rnd = exp_q + EW'(rnd_sum[MAN_W]);
        if (exp_rnd >= EMAX_S) begin
          flags_d = 4'b0101;
          unique case (rm_q)
            2'b00: z_d = inf_z;
            2'b01: z_d = max_z;
            2'b10: z_d = s_q ? max_z : inf_z;
            2'b11: z_d = s_q ? inf_z : max_z;
          endcase
        end else if (exp_rnd[EW-1] || ~|exp_rnd) begin
          z_d     = {s_q, {(W-1){1'b0}}};
          flags_d = 4'b0011;
        end else begin
          z_d     = {s_q, exp_rnd[EXP_W-1:0], rnd_sum[MAN_W-1:0]};
          flags_d = {3'b000, g_q || st_q};
        end
        state_d = PUT_Z;
      end
      PUT_Z: if (output_z_ack) state_d = GET_A;
      default: state_d = GET_A;
    endcase
    a_ack_d = (state_d == GET_A);
    b_ack_d = (state_d == GET_B);
    z_stb_d = (state_d == PUT_Z);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= GET_A;
      a_q     <= '0;
      b_q     <= '0;
      rm_q    <= '0;
      z_q     <= '0;
      flags_q <= '0;
      a_ack_q <= 1'b0;
      b_ack_q <= 1'b0;
      z_stb_q <= 1'b0;
      s_q     <= 1'b0;
      exp_q   <= '0;
      ma_q    <= '0;
      mb_q    <= '0;
      prod_q  <= '0;
      frac_q  <= '0;
      g_q     <= 1'b0;
      st_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rm_q    <= rm_d;
      z_q     <= z_d;
      flags_q <= flags_d;
      a_ack_q <= a_ack_d;
      b_ack_q <= b_ack_d;
      z_stb_q <= z_stb_d;
      s_q     <= s_d;
      exp_q   <= exp_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      prod_q  <= prod_d;
      frac_q  <= frac_d;
      g_q     <= g_d;
      st_q    <= st_d;
    end
  end

  assign input_a_ack  = a_ack_q;
  assign input_b_ack  = b_ack_q;
  assign output_z     = z_q;
  assign output_z_stb = z_stb_q;
  assign output_flags = flags_q;

endmodule

// File: tb/tb_fpu_multiplier_param.sv
// Bench for fpu_multiplier_param: binary32 vector table, handshake/reset
// sequences, and a binary16 random sweep against a real-valued reference.
module tb_fpu_multiplier_param;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        sel = 1'b0;
  logic [31:0] a_in = '0, b_in = '0;
  logic [1:0]  rm_in = '0;
  logic        a_stb = 1'b0, b_stb = 1'b0, z_ack = 1'b0;

  logic        a_ack32, b_ack32, zs32, a_ack16, b_ack16, zs16;
  logic [31:0] z32;
  logic [15:0] z16;
  logic [3:0]  f32, f16;

  logic        a_ack, b_ack, z_stb;
  logic [31:0] z_out;
  logic [3:0]  fl_out;
  assign a_ack  = sel ? a_ack16 : a_ack32;
  assign b_ack  = sel ? b_ack16 : b_ack32;
  assign z_stb  = sel ? zs16 : zs32;
  assign z_out  = sel ? {16'h0, z16} : z32;
  assign fl_out = sel ? f16 : f32;

  fpu_multiplier_param dut32 (
    .clk(clk), .rst(rst),
    .input_a(a_in), .input_a_stb(a_stb & ~sel), .input_a_ack(a_ack32), .input_rm(rm_in),
    .input_b(b_in), .input_b_stb(b_stb & ~sel), .input_b_ack(b_ack32),
    .output_z(z32), .output_z_stb(zs32), .output_z_ack(z_ack & ~sel), .output_flags(f32)
  );

  fpu_multiplier_param #(.EXP_W(5), .MAN_W(10)) dut16 (
    .clk(clk), .rst(rst),
    .input_a(a_in[15:0]), .input_a_stb(a_stb & sel), .input_a_ack(a_ack16), .input_rm(rm_in),
    .input_b(b_in[15:0]), .input_b_stb(b_stb & sel), .input_b_ack(b_ack16),
    .output_z(z16), .output_z_stb(zs16), .output_z_ack(z_ack & sel), .output_flags(f16)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic send_a(input logic [31:0] a, input logic [1:0] rm);
    int n;
    @(negedge clk);
    a_in = a; rm_in = rm; a_stb = 1'b1;
    n = 0;
    while (!a_ack && n < 50) begin @(negedge clk); n++; end
    chk("a_ack wait", {63'b0, a_ack}, 64'd1);
    @(posedge clk);
    #1 a_stb = 1'b0;
  endtask

  task automatic send_b(input logic [31:0] b);
    int n;
    @(negedge clk);
    b_in = b; b_stb = 1'b1;
    n = 0;
    while (!b_ack && n < 50) begin @(negedge clk); n++; end
    chk("b_ack wait", {63'b0, b_ack}, 64'd1);
    @(posedge clk);
    #1 b_stb = 1'b0;
  endtask

  task automatic wait_z(output int lat);
    lat = 0;
    while (!z_stb && lat < 50) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic take_z(input int hold, output logic [31:0] z, output logic [3:0] fl);
    z = z_out; fl = fl_out;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold stable", {25'b0, z_stb, a_ack, b_ack, fl_out, z_out},
          {25'b0, 1'b1, 1'b0, 1'b0, fl, z});
    end
    @(negedge clk); z_ack = 1'b1;
    @(posedge clk);
    #1 z_ack = 1'b0;
    chk("a_ack after z_ack", {62'b0, a_ack, z_stb}, {62'b0, 1'b1, 1'b0});
  endtask

  task automatic op(input logic [31:0] a, b, input logic [1:0] rm, input int hold,
                    output logic [31:0] z, output logic [3:0] fl, output int lat);
    send_a(a, rm);
    send_b(b);
    wait_z(lat);
    take_z(hold, z, fl);
    $display("op w%0d a=%h b=%h rm=%0d -> z=%h flags=%b lat=%0d", sel ? 16 : 32, a, b, rm, z, fl, lat);
  endtask

  // Reference: exact real-valued product, rounded to binary16 by value.
  function automatic void ref16(input logic [15:0] a, b, input logic [1:0] rm,
                                output logic [15:0] z, output logic [3:0] fl);
    logic s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, inc;
    int e, n;
    real p, q, rem;
    s = a[15] ^ b[15];
    a_nan = (a[14:10] == 5'd31) && (a[9:0] != 0);
    b_nan = (b[14:10] == 5'd31) && (b[9:0] != 0);
    a_inf = (a[14:10] == 5'd31) && (a[9:0] == 0);
    b_inf = (b[14:10] == 5'd31) && (b[9:0] == 0);
    a_zero = (a[14:10] == 5'd0);
    b_zero = (b[14:10] == 5'd0);
    fl = 4'b0000;
    if (a_nan || b_nan) begin
      z = 16'h7E00;
      fl[3] = (a_nan && !a[9]) || (b_nan && !b[9]);
    end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
      z = 16'h7E00; fl = 4'b1000;
    end else if (a_inf || b_inf) begin
      z = {s, 15'h7C00};
    end else if (a_zero || b_zero) begin
      z = {s, 15'h0000};
    end else begin
      p = (1.0 + real'(a[9:0]) / 1024.0) * (1.0 + real'(b[9:0]) / 1024.0);
      e = int'(a[14:10]) + int'(b[14:10]) - 15;
      while (p >= 2.0) begin p = p / 2.0; e++; end
      q = p * 1024.0;
      n = int'($floor(q));
      rem = q - real'(n);
      case (rm)
        2'd0:    inc = (rem > 0.5) || (rem == 0.5 && (n % 2) == 1);
        2'd1:    inc = 1'b0;
        2'd2:    inc = (rem > 0.0) && !s;
        default: inc = (rem > 0.0) && s;
      endcase
      if (inc) n++;
      if (n == 2048) begin n = 1024; e++; end
      if (e >= 31) begin
        fl = 4'b0101;
        case (rm)
          2'd0:    z = {s, 15'h7C00};
          2'd1:    z = {s, 15'h7BFF};
          2'd2:    z = s ? {s, 15'h7BFF} : {s, 15'h7C00};
          default: z = s ? {s, 15'h7C00} : {s, 15'h7BFF};
        endcase
      end else if (e <= 0) begin
        z = {s, 15'h0000}; fl = 4'b0011;
      end else begin
        z = {s, e[4:0], n[9:0]};
        fl = {3'b000, rem > 0.0};
      end
    end
  endfunction

  typedef struct {
    logic        sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  rm;
    logic [31:0] z;
    logic [3:0]  fl;
    int          lat;
  } vec_t;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t        vecs[$];
    logic [31:0] z;
    logic [3:0]  fl;
    logic [15:0] ez;
    logic [3:0]  efl;
    logic [15:0] ra, rb;
    logic [1:0]  rrm;
    int          lat;

    vecs.push_back('{1'b0, 32'h40000000, 32'h40400000, 2'd0, 32'h40C00000, 4'h0, 5});
    vecs.push_back('{1'b0, 32'h3F800000, 32'h42B1CCCD, 2'd0, 32'h42B1CCCD, 4'h0, 5});
    vecs.push_back('{1'b0, 32'h3F800001, 32'h3F800001, 2'd0, 32'h3F800002, 4'h1, 5});
    vecs.push_back('{1'b0, 32'h3F800001, 32'h3F800001, 2'd1, 32'h3F800002, 4'h1, 5});
    vecs.push_back('{1'b0, 32'h3F800001, 32'h3F800001, 2'd2, 32'h3F800003, 4'h1, 5});
    vecs.push_back('{1'b0, 32'h3F800001, 32'h3F800001, 2'd3, 32'h3F800002, 4'h1, 5});
    vecs.push_back('{1'b0, 32'hBF800001, 32'h3F800001, 2'd3, 32'hBF800003, 4'h1, 5});
    vecs.push_back('{1'b0, 32'h3FBFFFFF, 32'h3F2AAAAB, 2'd2, 32'h3F800000, 4'h1, 5});
    vecs.push_back('{1'b0, 32'h3FBFFFFF, 32'h3F2AAAAB, 2'd0, 32'h3F7FFFFF, 4'h1, 5});
    vecs.push_back('{1'b0, 32'h7F800000, 32'h00000000, 2'd0, 32'h7FC00000, 4'h8, 2});
    vecs.push_back('{1'b0, 32'h7F800001, 32'h3F800000, 2'd0, 32'h7FC00000, 4'h8, 2});
    vecs.push_back('{1'b0, 32'h7FC00000, 32'h3F800000, 2'd0, 32'h7FC00000, 4'h0, 2});
    vecs.push_back('{1'b0, 32'hFF800000, 32'h40000000, 2'd0, 32'hFF800000, 4'h0, 2});
    vecs.push_back('{1'b0, 32'h00400000, 32'h40000000, 2'd0, 32'h00000000, 4'h0, 2});
    vecs.push_back('{1'b0, 32'h7F000000, 32'h40000000, 2'd0, 32'h7F800000, 4'h5, 5});
    vecs.push_back('{1'b0, 32'h7F000000, 32'h40000000, 2'd1, 32'h7F7FFFFF, 4'h5, 5});
    vecs.push_back('{1'b0, 32'h7F000000, 32'h40000000, 2'd3, 32'h7F7FFFFF, 4'h5, 5});
    vecs.push_back('{1'b0, 32'hFF000000, 32'h40000000, 2'd2, 32'hFF7FFFFF, 4'h5, 5});
    vecs.push_back('{1'b0, 32'hFF000000, 32'h40000000, 2'd3, 32'hFF800000, 4'h5, 5});
    vecs.push_back('{1'b0, 32'h00800000, 32'h3F000000, 2'd0, 32'h00000000, 4'h3, 5});
    vecs.push_back('{1'b0, 32'h80800000, 32'h3F000000, 2'd0, 32'h80000000, 4'h3, 5});
    vecs.push_back('{1'b1, 32'h00003C00, 32'h00004000, 2'd0, 32'h00004000, 4'h0, 5});
    vecs.push_back('{1'b1, 32'h00007BFF, 32'h00004000, 2'd0, 32'h00007C00, 4'h5, 5});
    vecs.push_back('{1'b1, 32'h00007C00, 32'h00000000, 2'd0, 32'h00007E00, 4'h8, 2});

    // Reset state and first ack.
    repeat (2) @(negedge clk);
    chk("reset outputs", {27'b0, a_ack, b_ack, z_stb, fl_out, z_out}, 64'd0);
    rst = 1'b1;
    #1 chk("a_ack before first edge", {63'b0, a_ack}, 64'd0);
    @(posedge clk);
    #1 chk("a_ack after first edge", {63'b0, a_ack}, 64'd1);

    foreach (vecs[i]) begin
      sel = vecs[i].sel;
      op(vecs[i].a, vecs[i].b, vecs[i].rm, 0, z, fl, lat);
      chk($sformatf("vec%0d z", i), {32'b0, z}, {32'b0, vecs[i].z});
      chk($sformatf("vec%0d flags", i), {60'b0, fl}, {60'b0, vecs[i].fl});
      chk($sformatf("vec%0d latency", i), 64'(lat), 64'(vecs[i].lat));
    end
    sel = 1'b0;

    // B strobing before A must not be accepted.
    @(negedge clk);
    b_in = 32'h40400000; b_stb = 1'b1;
    repeat (3) @(negedge clk);
    chk("b_ack before A", {62'b0, b_ack, a_ack}, {62'b0, 1'b0, 1'b1});
    op(32'h40000000, 32'h40400000, 2'd0, 0, z, fl, lat);
    chk("b-first z", {32'b0, z}, {32'b0, 32'h40C00000});

    // Backpressure: hold output_z_ack low for 10 cycles.
    op(32'h3F800001, 32'h3F800001, 2'd2, 10, z, fl, lat);
    chk("backpressure z", {28'b0, fl, z}, {28'b0, 4'h1, 32'h3F800003});

    // Reset while in MULT aborts; a fresh operation then completes.
    send_a(32'h40000000, 2'd0);
    send_b(32'h40400000);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("reset mid-op outputs", {27'b0, a_ack, b_ack, z_stb, fl_out, z_out}, 64'd0);
    @(negedge clk); rst = 1'b1;
    op(32'h40000000, 32'h40400000, 2'd0, 0, z, fl, lat);
    chk("post-reset z", {28'b0, fl, z}, {28'b0, 4'h0, 32'h40C00000});
    chk("post-reset latency", 64'(lat), 64'd5);

    // Binary16 random sweep.
    sel = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      ra  = 16'($urandom_range(0, 65535));
      rb  = 16'($urandom_range(0, 65535));
      rrm = 2'($urandom_range(0, 3));
      ref16(ra, rb, rrm, ez, efl);
      op({16'h0, ra}, {16'h0, rb}, rrm, 0, z, fl, lat);
      chk($sformatf("rand%0d a=%h b=%h rm=%0d", i, ra, rb, rrm), {44'b0, fl, z[15:0]}, {44'b0, efl, ez});
    end
    sel = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
